// File: rtl/mem_arbiter_rr.sv
// N-requestor arbiter in front of a single memory port, with grant hold, completion pulse and response routing.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest index wins.
module mem_arbiter_rr #(
   parameter int NUM_RQ = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128,
   localparam int IDX_W = (NUM_RQ > 1) ? $clog2(NUM_RQ) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_RQ-1:0]          req_valid,
   input  logic [NUM_RQ-1:0]          req_rw,
   input  logic [NUM_RQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_RQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_RQ-1:0]          grant,
   output logic [NUM_RQ-1:0]          resp_valid,
   output logic [DATA_W-1:0]          resp_rdata,
   output logic                       mem_valid,
   output logic                       mem_rw,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic                       mem_ready,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       busy,
   output logic [IDX_W-1:0]           grant_idx
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] winner;
   logic             owner_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] hi_winner;
   logic [IDX_W-1:0] lo_winner;
   logic             hi_found;

   // Searching downward leaves the lowest qualifying index; prefer one at or above rr_ptr, else wrap.
   always_comb begin
      hi_winner = '0;
      lo_winner = '0;
      hi_found  = 1'b0;
      for (int i = NUM_RQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_winner = IDX_W'(i);
            if (IDX_W'(i) >= rr_ptr) begin
               hi_found  = 1'b1;
               hi_winner = IDX_W'(i);
            end
         end
      end
      winner = hi_found ? hi_winner : lo_winner;
   end
`else
   always_comb begin
      winner = '0;
      for (int i = NUM_RQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            winner = IDX_W'(i);
         end
      end
   end
`endif

   // Owner fields reach the memory port only in GRANT; other requestors never leak through.
   always_comb begin
      grant       = '0;
      resp_valid  = '0;
      owner_valid = 1'b0;
      mem_rw      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      if (state == GRANT) begin
         for (int i = 0; i < NUM_RQ; i++) begin
            if (owner == IDX_W'(i)) begin
               grant[i]      = 1'b1;
               owner_valid   = req_valid[i];
               mem_rw        = req_rw[i];
               mem_addr      = req_addr[i*ADDR_W +: ADDR_W];
               mem_wdata     = req_wdata[i*DATA_W +: DATA_W];
               resp_valid[i] = req_valid[i] & mem_ready;
            end
         end
      end
   end

   assign mem_valid  = owner_valid;
   assign resp_rdata = mem_rdata;
   assign busy       = (state == GRANT);
   assign grant_idx  = (state == GRANT) ? owner : '0;

   // Completion and withdrawal both return to IDLE, giving the one-cycle bubble between owners.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         rr_ptr <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  state <= GRANT;
                  owner <= winner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  rr_ptr <= (winner == IDX_W'(NUM_RQ - 1)) ? '0 : winner + 1'b1;
`endif
               end
            end
            GRANT: begin
               if (!owner_valid || mem_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed testbench for mem_arbiter_rr with four requestors; expectations follow the build's arbitration mode.
module tb_mem_arbiter_rr;

   localparam int NRQ = 4;
   localparam int AW  = 32;
   localparam int DW  = 128;

   logic              clk;
   logic              reset;
   logic [NRQ-1:0]    req_valid;
   logic [NRQ-1:0]    req_rw;
   logic [NRQ*AW-1:0] req_addr;
   logic [NRQ*DW-1:0] req_wdata;
   logic [NRQ-1:0]    grant;
   logic [NRQ-1:0]    resp_valid;
   logic [DW-1:0]     resp_rdata;
   logic              mem_valid;
   logic              mem_rw;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic              mem_ready;
   logic [DW-1:0]     mem_rdata;
   logic              busy;
   logic [1:0]        grant_idx;

   int checks   = 0;
   int failures = 0;
   int expOwner [5];

   mem_arbiter_rr #(.NUM_RQ(NRQ), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
      .grant(grant), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy), .grant_idx(grant_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and step just past the edge so inputs change away from it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      checks++;
      assert (observed === expected)
         else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         end
   endtask

   initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expOwner = '{0, 1, 2, 3, 0};
`else
      expOwner = '{0, 0, 0, 0, 0};
`endif
      reset     = 1'b1;
      req_valid = '0;
      req_rw    = '0;
      req_addr  = '0;
      req_wdata = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      #2;
      checkOutput("rst_grant", DW'(grant), DW'(0));
      checkOutput("rst_busy", DW'(busy), DW'(0));
      checkOutput("rst_mem_valid", DW'(mem_valid), DW'(0));
      checkOutput("rst_grant_idx", DW'(grant_idx), DW'(0));
      checkOutput("rst_mem_addr", DW'(mem_addr), DW'(0));
      checkOutput("rst_resp_valid", DW'(resp_valid), DW'(0));
      applyStimulus();
      reset = 1'b0;

      // Single request from requestor 1, completing in its third grant cycle
      req_valid = 4'b0010;
      req_addr[1*AW +: AW] = 32'h100;
      #1;
      checkOutput("single_latency_grant", DW'(grant), DW'(0));
      applyStimulus();
      #1;
      checkOutput("single_grant", DW'(grant), DW'(4'b0010));
      checkOutput("single_mem_valid", DW'(mem_valid), DW'(1));
      checkOutput("single_mem_addr", DW'(mem_addr), DW'(32'h100));
      checkOutput("single_mem_rw", DW'(mem_rw), DW'(0));
      checkOutput("single_grant_idx", DW'(grant_idx), DW'(1));
      checkOutput("single_no_resp", DW'(resp_valid), DW'(0));
      applyStimulus();
      #1;
      checkOutput("single_hold_busy", DW'(busy), DW'(1));
      applyStimulus();
      mem_ready = 1'b1;
      mem_rdata = DW'(8'hAB);
      #1;
      checkOutput("single_resp_valid", DW'(resp_valid), DW'(4'b0010));
      checkOutput("single_resp_rdata", resp_rdata, DW'(8'hAB));
      applyStimulus();
      req_valid = '0;
      #1;
      checkOutput("single_idle_busy", DW'(busy), DW'(0));
      checkOutput("single_idle_grant", DW'(grant), DW'(0));
      checkOutput("idle_ready_ignored", DW'(resp_valid), DW'(0));
      mem_ready = 1'b0;

      // Isolation: requestor 0 fields change while requestor 1 owns the port
      applyStimulus();
      req_valid = 4'b0010;
      req_rw    = 4'b0010;
      req_addr[1*AW +: AW]  = 32'h200;
      req_wdata[1*DW +: DW] = DW'(16'h1111);
      req_addr[0*AW +: AW]  = 32'h300;
      req_wdata[0*DW +: DW] = DW'(16'h2222);
      applyStimulus();
      #1;
      checkOutput("iso_mem_addr", DW'(mem_addr), DW'(32'h200));
      checkOutput("iso_mem_wdata", mem_wdata, DW'(16'h1111));
      checkOutput("iso_mem_rw", DW'(mem_rw), DW'(1));
      req_addr[0*AW +: AW]  = 32'hDEAD_BEEF;
      req_wdata[0*DW +: DW] = DW'(16'h5555);
      #1;
      checkOutput("iso_toggle_addr", DW'(mem_addr), DW'(32'h200));
      checkOutput("iso_toggle_wdata", mem_wdata, DW'(16'h1111));

      // Withdrawal beats a simultaneous mem_ready
      applyStimulus();
      req_valid = '0;
      mem_ready = 1'b1;
      #1;
      checkOutput("wd_mem_valid", DW'(mem_valid), DW'(0));
      checkOutput("wd_resp_valid", DW'(resp_valid), DW'(0));
      applyStimulus();
      mem_ready = 1'b0;
      #1;
      checkOutput("wd_idle_busy", DW'(busy), DW'(0));

      // Fresh reset, then all four request continuously with immediate completion
      reset = 1'b1;
      #1;
      checkOutput("rst2_busy", DW'(busy), DW'(0));
      reset     = 1'b0;
      req_valid = 4'b1111;
      mem_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         applyStimulus();
         #1;
         checkOutput($sformatf("arb_owner_%0d", g), DW'(grant_idx), DW'(expOwner[g]));
         checkOutput($sformatf("arb_resp_%0d", g), DW'(resp_valid), DW'(4'(1 << expOwner[g])));
         applyStimulus();
         #1;
         checkOutput($sformatf("arb_bubble_%0d", g), DW'(busy), DW'(0));
      end
      req_valid = 4'b1110;
      applyStimulus();
      #1;
      checkOutput("drop0_owner", DW'(grant_idx), DW'(1));

      // Asynchronous reset between edges while requestor 3 owns the port
      applyStimulus();
      req_valid = 4'b1000;
      mem_ready = 1'b0;
      applyStimulus();
      #1;
      checkOutput("pre_rst_owner", DW'(grant_idx), DW'(3));
      reset = 1'b1;
      #1;
      checkOutput("async_rst_grant", DW'(grant), DW'(0));
      checkOutput("async_rst_mem_valid", DW'(mem_valid), DW'(0));
      checkOutput("async_rst_busy", DW'(busy), DW'(0));
      #1;
      reset     = 1'b0;
      req_valid = 4'b0100;
      applyStimulus();
      #1;
      checkOutput("post_rst_owner", DW'(grant_idx), DW'(2));
      checkOutput("post_rst_grant", DW'(grant), DW'(4'b0100));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
